// File: rtl/instr_sequencer.sv
// Instruction sequencer: holds a small loadable program and issues one
// instruction at a time downstream over a valid/ready handshake, stepping
// a program counter from 0 up to the latched program length.
module instr_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int REG_AW  = 2,
  parameter int INSTR_W = 3 + 3*REG_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  input  logic               abort,
  input  logic               issue_ready,
  output logic               issue_valid,
  output logic [2:0]         opcode,
  output logic [REG_AW-1:0]  rd,
  output logic [REG_AW-1:0]  rs1,
  output logic [REG_AW-1:0]  rs2,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [INSTR_W-1:0]  mem [DEPTH];
  logic [INSTR_W-1:0]  instr_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     pc_inc;
  logic                launch;
  logic                handshake;
  logic                last;

  // abort has priority over both start (in IDLE) and a completing handshake.
  assign launch    = (state == S_IDLE) && start && !abort;
  assign handshake = (state == S_ISSUE) && issue_ready && !abort;
  // Computed one bit wider than pc so a full-depth program never wraps.
  assign pc_inc    = {1'b0, pc_q} + LEN_ONE;
  assign last      = (pc_inc == len_q);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (launch) state_nxt = (prog_len == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_nxt = abort ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        if (abort)          state_nxt = S_DONE;
        else if (handshake) state_nxt = last ? S_DONE : S_FETCH;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Program counter and issued-instruction register; the register only
  // reloads in FETCH, so fields stay frozen while ISSUE waits on ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      if (launch)                pc_q <= '0;
      else if (handshake && !last) pc_q <= pc_inc[ADDR_W-1:0];
      if (state == S_FETCH)      instr_q <= mem[pc_q];
    end
  end

  // Program memory writes and run-length capture.
  // NOTE: memory and length are deliberately left out of reset: a reset must
  // preserve the loaded program, and a memory array with reset would not map
  // onto RAM.
  always_ff @(posedge clk) begin
    if (load_en && (state == S_IDLE || state == S_DONE))
      mem[load_addr] <= load_data;
    if (launch)
      len_q <= (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
  end

  assign issue_valid           = (state == S_ISSUE);
  assign {opcode, rd, rs1, rs2} = instr_q;
  assign pc                    = pc_q;
  assign busy                  = (state == S_FETCH) || (state == S_ISSUE);
  assign done                  = (state == S_DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. The reference model is the list of
// loaded words: a run of length L must hand over words 0..min(L,16)-1 in order,
// each exactly once, with timing rules checked where the spec fixes them.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic [3:0] load_addr;
  logic [8:0] load_data;
  logic [4:0] prog_len;
  logic       start;
  logic       abort;
  logic       issue_ready;
  logic       issue_valid;
  logic [2:0] opcode;
  logic [1:0] rd, rs1, rs2;
  logic [3:0] pc;
  logic       busy;
  logic       done;

  logic [8:0] model [16];
  int         n_checks = 0;
  int         n_pass   = 0;

  instr_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .prog_len    (prog_len),
    .start       (start),
    .abort       (abort),
    .issue_ready (issue_ready),
    .issue_valid (issue_valid),
    .opcode      (opcode),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs read afterwards reflect that edge, inputs set
  // afterwards are sampled on the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [8:0] data);
    load_en   = 1'b1;
    load_addr = addr[3:0];
    load_data = data;
    step();
    load_en   = 1'b0;
    model[addr] = data;
  endtask

  // One complete run. mode 0: ready always high, 1: random ready,
  // 2: ready held low 5 cycles on the 2nd instruction. abort_idx >= 0 aborts
  // while that instruction is presented. load0 writes word 0 together with start.
  task automatic run(input int len, input int mode, input int abort_idx,
                     input bit load0 = 1'b0, input logic [8:0] d0 = 9'h0);
    int         exp_n, got, cyc, first_v, done_cyc, abort_cyc, bp_left;
    bit         prev_stall;
    logic [8:0] held;
    exp_n = (len > 16) ? 16 : len;
    if (abort_idx >= 0 && abort_idx < exp_n) exp_n = abort_idx;
    prog_len = len[4:0];
    start    = 1'b1;
    if (load0) begin
      load_en   = 1'b1;
      load_addr = 4'd0;
      load_data = d0;
      model[0]  = d0;
    end
    step();
    start = 1'b0; load_en = 1'b0;
    got = 0; cyc = 1; first_v = -1; done_cyc = -1; abort_cyc = -1;
    bp_left = 5; prev_stall = 1'b0; held = '0;
    while (cyc < 400) begin
      if (prev_stall) check("stall_hold", {issue_valid, opcode, rd, rs1, rs2}, {1'b1, held});
      if (issue_valid && first_v < 0) begin
        first_v = cyc;
        check("busy_in_issue", busy, 1);
      end
      if (done) begin
        done_cyc = cyc;
        check("done_valid_low", issue_valid, 0);
        break;
      end
      abort       = 1'b0;
      issue_ready = 1'($urandom_range(0, 1));
      prev_stall  = 1'b0;
      if (issue_valid) begin
        if (abort_idx == got) begin
          abort = 1'b1; issue_ready = 1'b1; abort_cyc = cyc;
        end else if (mode == 0) begin
          issue_ready = 1'b1;
        end else if (mode == 2) begin
          issue_ready = 1'b1;
          if (got == 1 && bp_left > 0) begin issue_ready = 1'b0; bp_left--; end
        end
        if (issue_ready && !abort) begin
          check("instr", {opcode, rd, rs1, rs2}, model[got]);
          check("pc", pc, got);
          got++;
        end
        prev_stall = !issue_ready && !abort;
        held       = {opcode, rd, rs1, rs2};
      end
      step();
      cyc++;
    end
    abort = 1'b0; issue_ready = 1'b0;
    check("done_seen", (done_cyc >= 0), 1);
    check("accept_count", got, exp_n);
    if (len == 0) check("no_valid_len0", first_v, -1);
    else          check("first_valid_latency", first_v, 2);
    if (abort_cyc >= 0)            check("abort_done_next", done_cyc, abort_cyc + 1);
    else if (mode == 0)            check("done_time", done_cyc, 2*exp_n + 1);
    step();
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; prog_len = '0;
    start = 1'b0; abort = 1'b0; issue_ready = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    step(); step(); step();
    rst = 1'b0;
    check("rst_valid", issue_valid, 0);
    check("rst_fields", {opcode, rd, rs1, rs2}, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Load program words 0..15 so every address has known contents.
    for (int i = 0; i < 16; i++) load(i, 9'($urandom));

    // start together with abort in IDLE does nothing.
    prog_len = 5'd3; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_done", done, 0);

    // Three-instruction program, ready high.
    load(0, 9'b000_01_10_11);
    load(1, 9'b001_11_00_01);
    load(2, 9'b111_10_01_00);
    run(3, 0, -1);
    // Backpressure on the second instruction.
    run(3, 2, -1);
    // Empty program.
    run(0, 0, -1);

    // Full depth, then a clamped over-length request.
    for (int i = 0; i < 16; i++) load(i, 9'($urandom));
    run(16, 0, -1);
    run(17, 0, -1);
    run(31, 1, -1);

    // Abort while presenting the third instruction with ready high.
    run(5, 0, 2);
    run(8, 1, 0);

    // load_en together with start: the first fetch sees the new word 0.
    run(4, 0, -1, 1'b1, 9'b101_00_11_10);

    // Randomized runs.
    for (int k = 0; k < 8; k++) begin
      int len, ab;
      len = $urandom_range(0, 20);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16) : -1;
      run(len, 1, ab);
    end

    // Reset while the second instruction is stalled, with load_en attempted
    // during FETCH and ISSUE (must be ignored).
    prog_len = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    load_en = 1'b1; load_addr = 4'd0; load_data = ~model[0];
    step();
    load_en = 1'b0;
    check("busy_issue_valid", issue_valid, 1);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    load_en = 1'b1; load_addr = 4'd1; load_data = ~model[1];
    step();
    load_en = 1'b0;
    check("second_issue_valid", issue_valid, 1);
    check("second_issue_pc", pc, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun_rst_valid", issue_valid, 0);
    check("midrun_rst_fields", {opcode, rd, rs1, rs2}, 0);
    check("midrun_rst_pc", pc, 0);
    check("midrun_rst_busy", busy, 0);
    check("midrun_rst_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_done_after_rst", done, 0);
    end
    // Memory survived both the ignored writes and the reset.
    run(4, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
